bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD counter with up/down counting, count enable, synchronous parallel load with BCD validity check, and selectable wrap or saturate behaviour at the count limits. It replaces the single-digit binary-count-plus-adder-correction decade counter. Each digit counts natively in BCD, and a digit-to-digit carry/borrow chain extends the count range. It sits in front of the seven-segment display path and drives one BCD nibble per digit.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD digits, legal range 1..8. Count range is 0 .. 10^DIGITS−1.
- `WRAP`, default 1: limit behaviour. 1 = wrap around at the limits; 0 = saturate at the limits.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high. Clears all state immediately.
- `en`, input, 1 bit: count enable. Ignored while `load`=1.
- `up`, input, 1 bit: count direction. 1 = increment, 0 = decrement.
- `load`, input, 1 bit: synchronous parallel load request. Has priority over `en`.
- `d`, input, 4*DIGITS bits: load value. Digit i occupies `d[4i+3:4i]`; digit 0 is the least significant.
- `q`, output, 4*DIGITS bits: current count in packed BCD, same digit layout as `d`.
- `tc`, output, 1 bit: terminal count, combinational from `q` and `up`.
  - `up`=1: high when every digit of `q` is 9.
  - `up`=0: high when `q` is 0.
- `ovf`, output, 1 bit: registered one-cycle pulse on a limit event.
- `load_err`, output, 1 bit: registered one-cycle pulse when a load is rejected.

## Operation
- Reset, asynchronous: `q`=0, `ovf`=0, `load_err`=0. Counting resumes on the first rising edge after `reset` deasserts.
- Per-edge priority: `load` > `en` > hold.
- Load:
  - If every nibble of `d` is ≤ 9: `q`←`d`, `ovf`=0, `load_err`=0.
  - If any nibble of `d` is > 9: `q` holds, `load_err`=1 for exactly that cycle, `ovf`=0.
- Count (`load`=0, `en`=1), digit i:
  - Increments when `up`=1 and digits 0..i−1 are all 9.
  - Decrements when `up`=0 and digits 0..i−1 are all 0.
  - Increment of 9 gives 0. Decrement of 0 gives 9.
  - Nibble values above 9 are unreachable, because only validated loads and BCD arithmetic write `q`.
- Limit event: a count step taken while `tc`=1.
  - `WRAP`=1: `q` wraps (all-9 → 0 when counting up; 0 → all-9 when counting down) and `ovf`=1 for that cycle.
  - `WRAP`=0: `q` holds at the limit and `ovf`=1 for every cycle in which a step is attempted.
- Hold (`load`=0, `en`=0): `q` holds; `ovf`=0 and `load_err`=0.
- `ovf` and `load_err` are never high in the same cycle.
- Changing `up` while `en`=1 takes effect on the next edge. There is no turnaround penalty.

## Timing
- Latency: `q`, `ovf` and `load_err` update one clock after the sampled inputs, on the same edge.
- `tc` is combinational and reflects the current `q` and `up` in the same cycle. No registered lag.
- The carry/borrow chain is resolved within one cycle for all `DIGITS`. There is no ripple latency across edges.
- `reset` asserted mid-count clears `q` without waiting for a clock edge. An edge that arrives while `reset`=1 has no effect.
- `load` and `en` both high: load wins and no count occurs. If the load is rejected, `q` also does not count.

## Test plan
All scenarios use `DIGITS`=2 unless stated otherwise.
- Reset then count up: `en`=1, `up`=1 for 100 cycles → `q` steps 00, 01 … 09, 10 … 99, then 00.
  - `ovf` pulses exactly once, on the 99→00 edge.
  - `tc`=1 only while `q`=99.
- Count down across the digit boundary: load 10, then `up`=0, `en`=1 → `q` goes 09, 08 … 00.
  - `WRAP`=1: next edge gives 99 with `ovf`=1.
  - `WRAP`=0: `q` stays at 00 and `ovf`=1 on every further enabled edge.
- Load validation:
  - `d`=0x47 → `q`=47, `load_err`=0.
  - `d`=0x4A → `q` stays 47, `load_err`=1 for one cycle.
  - `d`=0xF3 → `q` unchanged, `load_err` pulses.
- Priority: `load`=1, `en`=1, `d`=0x25 → `q`=25 with no increment. Next cycle with `en`=1 → `q`=26.
- Asynchronous reset mid-count: assert `reset` between edges while `q`=58 → `q`=00 before the next edge. `ovf` and `load_err` are 0.
- Direction flip and hold: at `q`=30 toggle `up` every cycle with `en`=1 → `q` alternates 29, 30, 29 …. With `en`=0, `q` is stable for 5 cycles.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//
// Multi-digit packed-BCD up/down counter. Each digit counts natively in BCD.
// A carry/borrow chain, resolved within one cycle, links the digits.
// It supports:
// - a synchronous parallel load with a BCD validity check,
// - wrap or saturate behaviour at the count limits, selected by WRAP.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); range 0 .. 10^DIGITS-1
//   WRAP     1 = wrap at the limits, 0 = saturate at the limits
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset; clears q, ovf, load_err
//   en        count enable (ignored while load=1)
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous load request, priority over en
//   d         load value, digit i at d[4i+3:4i], digit 0 least significant
//   q         current count, same layout as d
//   tc        terminal count (combinational): all-9 when up, zero when down
//   ovf       one-cycle registered pulse on a count step taken while tc=1
//   load_err  one-cycle registered pulse when a load carries a nibble > 9
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              load_err_q, load_err_d;

  // inc_step[i] / dec_step[i]: all lower digits are 9 / 0, so digit i moves.
  logic [DIGITS-1:0] inc_step, dec_step;
  logic              all_nine, all_zero;
  logic              d_valid;
  logic [W-1:0]      q_stepped;

  // Carry/borrow chain and load validity. A running AND is used instead of
  // a self-referencing prefix vector so the chain stays a clean comb cone.
  always_comb begin
    logic run9;
    logic run0;
    logic dv;
    run9 = 1'b1;
    run0 = 1'b1;
    dv   = 1'b1;
    inc_step = '0;
    dec_step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc_step[i] = run9;
      dec_step[i] = run0;
      run9 = run9 & (q_q[4*i +: 4] == 4'd9);
      run0 = run0 & (q_q[4*i +: 4] == 4'd0);
      dv   = dv & (d[4*i +: 4] <= 4'd9);
    end
    all_nine = run9;
    all_zero = run0;
    d_valid  = dv;
  end

  assign tc = up ? all_nine : all_zero;

  // One BCD step in the current direction. At the limits every digit rolls
  // over, which is exactly the wrap result (all-9 -> 0, 0 -> all-9).
  always_comb begin
    logic [3:0] dig;
    q_stepped = q_q;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i +: 4];
      if (up && inc_step[i]) begin
        q_stepped[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      end else if (!up && dec_step[i]) begin
        q_stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
    end
  end

  // Priority: load > en > hold. A rejected load blocks counting as well.
  always_comb begin
    q_d        = q_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (d_valid) begin
        q_d = d;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      ovf_d = tc;
      // Saturating build holds at the limit but still flags every attempt.
      if (!tc || WRAP) begin
        q_d = q_stepped;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter, DIGITS=2.
// One instance wraps (WRAP=1), one saturates (WRAP=0); both share stimulus.
module tb_bcd_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] d;
  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s;
  logic       ovf_w, ovf_s;
  logic       le_w, le_s;

  int unsigned n_checks;
  int unsigned n_fail;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_wrap (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .d        (d),
    .q        (q_w),
    .tc       (tc_w),
    .ovf      (ovf_w),
    .load_err (le_w)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .d        (d),
    .q        (q_s),
    .tc       (tc_s),
    .ovf      (ovf_s),
    .load_err (le_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-digit decimal value as packed BCD.
  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    en    = 1'b0;
    up    = 1'b1;
    load  = 1'b0;
    d     = 8'h00;
    #2;
    check_eq("rst_q_w", 32'(q_w), 32'h00);
    check_eq("rst_ovf_w", 32'(ovf_w), 32'h0);
    check_eq("rst_le_w", 32'(le_w), 32'h0);
    check_eq("rst_q_s", 32'(q_s), 32'h00);
    tick();
    reset = 1'b0;

    // Count up 100 edges: wrap instance returns to 00, saturate sticks at 99.
    en = 1'b1;
    up = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      check_eq("up_tc_w", 32'(tc_w), 32'(i == 100));
      tick();
      check_eq("up_q_w", 32'(q_w), 32'(bcd2(i % 100)));
      check_eq("up_ovf_w", 32'(ovf_w), 32'(i == 100));
      check_eq("up_q_s", 32'(q_s), 32'(bcd2(i > 99 ? 99 : i)));
      check_eq("up_ovf_s", 32'(ovf_s), 32'(i == 100));
    end

    // Count down across the digit boundary from 10.
    en   = 1'b0;
    load = 1'b1;
    d    = 8'h10;
    tick();
    check_eq("ld10_q_w", 32'(q_w), 32'h10);
    check_eq("ld10_q_s", 32'(q_s), 32'h10);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      tick();
      check_eq("dn_q_w", 32'(q_w), 32'(bcd2(k)));
      check_eq("dn_q_s", 32'(q_s), 32'(bcd2(k)));
      check_eq("dn_ovf_w", 32'(ovf_w), 32'h0);
    end
    check_eq("dn_tc0_w", 32'(tc_w), 32'h1);
    up = 1'b1;
    #1;
    check_eq("up_tc0_w", 32'(tc_w), 32'h0);
    up = 1'b0;
    tick();
    check_eq("wrap_q_w", 32'(q_w), 32'h99);
    check_eq("wrap_ovf_w", 32'(ovf_w), 32'h1);
    check_eq("sat_q_s", 32'(q_s), 32'h00);
    check_eq("sat_ovf_s", 32'(ovf_s), 32'h1);
    check_eq("dn_tc99_w", 32'(tc_w), 32'h0);
    tick();
    check_eq("wrap2_q_w", 32'(q_w), 32'h98);
    check_eq("wrap2_ovf_w", 32'(ovf_w), 32'h0);
    check_eq("sat2_q_s", 32'(q_s), 32'h00);
    check_eq("sat2_ovf_s", 32'(ovf_s), 32'h1);
    tick();
    check_eq("sat3_ovf_s", 32'(ovf_s), 32'h1);

    // Load validation.
    en   = 1'b0;
    load = 1'b1;
    d    = 8'h47;
    tick();
    check_eq("ld47_q", 32'(q_w), 32'h47);
    check_eq("ld47_le", 32'(le_w), 32'h0);
    d = 8'h4A;
    tick();
    check_eq("ld4a_q", 32'(q_w), 32'h47);
    check_eq("ld4a_le", 32'(le_w), 32'h1);
    check_eq("ld4a_ovf", 32'(ovf_w), 32'h0);
    load = 1'b0;
    tick();
    check_eq("le_pulse_end", 32'(le_w), 32'h0);
    load = 1'b1;
    d    = 8'hF3;
    tick();
    check_eq("ldf3_q", 32'(q_w), 32'h47);
    check_eq("ldf3_le", 32'(le_w), 32'h1);
    // Rejected load with en=1 must not count either.
    en = 1'b1;
    up = 1'b1;
    d  = 8'h4A;
    tick();
    check_eq("rej_en_q", 32'(q_w), 32'h47);
    check_eq("rej_en_le", 32'(le_w), 32'h1);

    // Priority: load beats en.
    d = 8'h25;
    tick();
    check_eq("prio_q", 32'(q_w), 32'h25);
    check_eq("prio_le", 32'(le_w), 32'h0);
    check_eq("prio_ovf", 32'(ovf_w), 32'h0);
    load = 1'b0;
    tick();
    check_eq("prio_next_q", 32'(q_w), 32'h26);

    // Async reset clears a pending ovf pulse.
    load = 1'b1;
    d    = 8'h99;
    tick();
    load = 1'b0;
    tick();
    check_eq("pre_rst_ovf", 32'(ovf_w), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_ovf", 32'(ovf_w), 32'h0);
    check_eq("arst_q0", 32'(q_w), 32'h00);
    #1;
    reset = 1'b0;

    // Async reset mid-count at 58, held across an edge.
    load = 1'b1;
    d    = 8'h57;
    tick();
    load = 1'b0;
    tick();
    check_eq("pre_rst_q", 32'(q_w), 32'h58);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_q", 32'(q_w), 32'h00);
    check_eq("arst_le", 32'(le_w), 32'h0);
    tick();
    check_eq("rst_hold_q", 32'(q_w), 32'h00);
    #2;
    reset = 1'b0;
    tick();
    check_eq("resume_q", 32'(q_w), 32'h01);

    // Direction flip at 30, then hold.
    load = 1'b1;
    d    = 8'h30;
    tick();
    load = 1'b0;
    up   = 1'b0;
    tick();
    check_eq("flip1_q", 32'(q_w), 32'h29);
    up = 1'b1;
    tick();
    check_eq("flip2_q", 32'(q_w), 32'h30);
    up = 1'b0;
    tick();
    check_eq("flip3_q", 32'(q_w), 32'h29);
    up = 1'b1;
    tick();
    check_eq("flip4_q", 32'(q_w), 32'h30);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("hold_q", 32'(q_w), 32'h30);
      check_eq("hold_ovf", 32'(ovf_w), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
